axis_reduce_engine: RTL
=======================

Name: axis_reduce_engine

Overview:
- AXI-Stream NoC endpoint that reduces a variable-length operand packet, delimited by TLAST, to a single result beat.
- Reduction mode is selectable per packet: sum, difference, min or max.
- The result is returned as a one-beat packet to a programmable destination, and the source TID is preserved.
- Next-generation arithmetic tile on the Simple_NoC router ports; it replaces the fixed two-operand adder.

Parameters:
- TDATAW, 32, stream data width and operand/result width
- TDESTW, 4, TDEST width
- TIDW, 2, TID width
- CNTW, 16, width of beat and packet counters
- SIGNED_CMP, 0, 1 = min/max compare operands as two's complement; 0 = unsigned

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous, active-low reset
- MODE  in  2  00 sum, 01 difference (first minus rest), 10 min, 11 max; sampled on first beat
- RESULT_DEST  in  TDESTW  TDEST driven on result beat; sampled on first beat
- AXIS_S_TVALID  in  1  slave valid
- AXIS_S_TREADY  out  1  slave ready
- AXIS_S_TDATA  in  TDATAW  operand
- AXIS_S_TLAST  in  1  last operand of packet
- AXIS_S_TID  in  TIDW  source id
- AXIS_S_TDEST  in  TDESTW  ignored
- AXIS_M_TVALID  out  1  result valid
- AXIS_M_TREADY  in  1  downstream ready
- AXIS_M_TDATA  out  TDATAW  reduction result
- AXIS_M_TLAST  out  1  always 1 when TVALID
- AXIS_M_TID  out  TIDW  TID captured from first beat
- AXIS_M_TDEST  out  TDESTW  captured RESULT_DEST
- OVF  out  1  sticky: sum/difference wrapped in any packet since reset
- BEAT_CNT  out  CNTW  operands accepted in current packet, saturating
- PKT_CNT  out  CNTW  results delivered since reset, wraps

Behaviour:
- Reset (async, RST_N=0) forces the following, regardless of state (mid-packet data is discarded, no partial result emitted):
  - state IDLE; AXIS_S_TREADY=0 during reset
  - all AXIS_M_* outputs 0
  - OVF=0, BEAT_CNT=0, PKT_CNT=0
  - accumulator, captured MODE, TID and DEST = 0
- All AXIS_M_* outputs are registered; no combinational path from slave inputs to master outputs.
- States:
  - IDLE: TREADY=1. On handshake (TVALID&TREADY):
    - load acc=TDATA; capture MODE, TID, RESULT_DEST; BEAT_CNT=1
    - if TLAST go to SEND, else go to ACCUM
  - ACCUM: TREADY=1. On each handshake:
    - acc = acc op TDATA; BEAT_CNT += 1, saturating at 2^CNTW-1
    - if TLAST go to SEND
  - SEND: TREADY=0; M_TVALID=1, M_TDATA=acc, M_TLAST=1, M_TID/M_TDEST = captured values.
    - On M_TREADY: M_TVALID=0 next cycle, PKT_CNT += 1, BEAT_CNT=0, go to IDLE.
- Latency: M_TVALID rises exactly 1 cycle after the TLAST beat handshake. Back-to-back packets have a minimum of 1 idle TREADY=0 cycle per result plus the SEND hold time.
- Holding rule: while M_TVALID=1 and M_TREADY=0, every M_* output is held stable. TVALID never drops without a handshake.
- Arithmetic:
  - sum and difference are modulo 2^TDATAW
  - OVF sets on unsigned carry-out for sum and unsigned borrow for difference
  - OVF is never cleared except by reset
  - min/max use SIGNED_CMP; ties keep the accumulator
- Single-beat packet (TLAST on first beat): result = that operand in every mode; OVF unchanged.
- MODE or RESULT_DEST changes mid-packet have no effect until the next first beat.
- Slave TVALID with TREADY=0 (SEND state): the beat stays pending upstream and is not accepted.
- TDEST on the slave side is ignored.

Test Plan:
- Sum, 2 operands: MODE=00, beats 5, 7(TLAST), TID=2, RESULT_DEST=4'h3 -> one result beat TDATA=12, TLAST=1, TID=2, TDEST=3, 1 cycle after beat 2; PKT_CNT=1.
- Wrap and backpressure: MODE=00, beats 0xFFFFFFFF, 0x2(TLAST); hold M_TREADY=0 for 5 cycles -> TDATA=0x1 held stable for 5 cycles, OVF=1; S_TREADY=0 throughout.
- Min/max signedness:
  - MODE=10, SIGNED_CMP=1, beats 3, 0xFFFFFFFE, 9(TLAST) -> 0xFFFFFFFE.
  - Same beats with SIGNED_CMP=0 -> 3.
- Difference and single beat: MODE=01, beats 10, 3, 4(TLAST) -> 3. Then MODE=11, single beat 42 with TLAST -> 42; BEAT_CNT was 1 before SEND.
- Mid-packet MODE change: MODE=00 at beat 1, switched to 11 at beat 2; beats 1, 2, 3(TLAST) -> 6.
- Reset mid-operation: assert RST_N=0 after 2 of 4 beats -> no result emitted, all outputs 0. After release, a fresh 2-beat sum packet of 1, 1 gives 2; PKT_CNT=1.

Source files
------------

// File: rtl/axis_reduce_engine.sv
// AXI-Stream reduction endpoint: folds a TLAST-delimited operand packet into one
// result beat using sum, difference, min or max, selected on the packet's first beat.
module axis_reduce_engine #(
    parameter int TDATAW     = 32,
    parameter int TDESTW     = 4,
    parameter int TIDW       = 2,
    parameter int CNTW       = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [1:0]        MODE,
    input  logic [TDESTW-1:0] RESULT_DEST,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TIDW-1:0]   AXIS_M_TID,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic              OVF,
    output logic [CNTW-1:0]   BEAT_CNT,
    output logic [CNTW-1:0]   PKT_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    localparam logic [1:0] M_SUM = 2'b00;
    localparam logic [1:0] M_DIF = 2'b01;
    localparam logic [1:0] M_MIN = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [TDATAW-1:0] acc_q, acc_d;
    logic [1:0]        mode_q, mode_d;
    logic [TIDW-1:0]   tid_q, tid_d;
    logic [TDESTW-1:0] dest_q, dest_d;
    logic              ovf_q, ovf_d;
    logic [CNTW-1:0]   beat_q, beat_d;
    logic [CNTW-1:0]   pkt_q, pkt_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [TDATAW-1:0] m_data_q, m_data_d;
    logic [TIDW-1:0]   m_tid_q, m_tid_d;
    logic [TDESTW-1:0] m_dest_q, m_dest_d;

    logic              s_ready, s_hs, m_hs;
    logic [TDATAW:0]   sum_ext;
    logic [TDATAW-1:0] dif, op_res;
    logic              op_ovf, d_lt_acc, d_gt_acc;
    logic              unused_tdest;

    assign unused_tdest = ^AXIS_S_TDEST;

    // Ready is gated by reset so nothing is accepted while RST_N is low.
    assign s_ready       = RST_N && (state_q != S_SEND);
    assign AXIS_S_TREADY = s_ready;
    assign s_hs          = AXIS_S_TVALID && s_ready;
    assign m_hs          = m_valid_q && AXIS_M_TREADY;

    assign sum_ext = {1'b0, acc_q} + {1'b0, AXIS_S_TDATA};
    assign dif     = acc_q - AXIS_S_TDATA;

    always_comb begin
        if (SIGNED_CMP) begin
            d_lt_acc = $signed(AXIS_S_TDATA) < $signed(acc_q);
            d_gt_acc = $signed(AXIS_S_TDATA) > $signed(acc_q);
        end else begin
            d_lt_acc = AXIS_S_TDATA < acc_q;
            d_gt_acc = AXIS_S_TDATA > acc_q;
        end
    end

    always_comb begin
        op_ovf = 1'b0;
        case (mode_q)
            M_SUM: begin
                op_res = sum_ext[TDATAW-1:0];
                op_ovf = sum_ext[TDATAW];
            end
            M_DIF: begin
                op_res = dif;
                op_ovf = acc_q < AXIS_S_TDATA;
            end
            M_MIN:   op_res = d_lt_acc ? AXIS_S_TDATA : acc_q;
            default: op_res = d_gt_acc ? AXIS_S_TDATA : acc_q;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no latch is inferred.
        state_d   = state_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        tid_d     = tid_q;
        dest_d    = dest_q;
        ovf_d     = ovf_q;
        beat_d    = beat_q;
        pkt_d     = pkt_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_tid_d   = m_tid_q;
        m_dest_d  = m_dest_q;
        case (state_q)
            S_IDLE: if (s_hs) begin
                acc_d   = AXIS_S_TDATA;
                mode_d  = MODE;
                tid_d   = AXIS_S_TID;
                dest_d  = RESULT_DEST;
                beat_d  = {{(CNTW-1){1'b0}}, 1'b1};
                state_d = S_ACCUM;
                if (AXIS_S_TLAST) begin
                    state_d   = S_SEND;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    m_data_d  = AXIS_S_TDATA;
                    m_tid_d   = AXIS_S_TID;
                    m_dest_d  = RESULT_DEST;
                end
            end
            S_ACCUM: if (s_hs) begin
                acc_d = op_res;
                ovf_d = ovf_q | op_ovf;
                if (beat_q != {CNTW{1'b1}}) beat_d = beat_q + 1'b1;
                if (AXIS_S_TLAST) begin
                    state_d   = S_SEND;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    m_data_d  = op_res;
                    m_tid_d   = tid_q;
                    m_dest_d  = dest_q;
                end
            end
            S_SEND: if (m_hs) begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                pkt_d     = pkt_q + 1'b1;
                beat_d    = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mode_q    <= '0;
            tid_q     <= '0;
            dest_q    <= '0;
            ovf_q     <= 1'b0;
            beat_q    <= '0;
            pkt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_tid_q   <= '0;
            m_dest_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            tid_q     <= tid_d;
            dest_q    <= dest_d;
            ovf_q     <= ovf_d;
            beat_q    <= beat_d;
            pkt_q     <= pkt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_tid_q   <= m_tid_d;
            m_dest_q  <= m_dest_d;
        end
    end

    assign AXIS_M_TVALID = m_valid_q;
    assign AXIS_M_TLAST  = m_last_q;
    assign AXIS_M_TDATA  = m_data_q;
    assign AXIS_M_TID    = m_tid_q;
    assign AXIS_M_TDEST  = m_dest_q;
    assign OVF           = ovf_q;
    assign BEAT_CNT      = beat_q;
    assign PKT_CNT       = pkt_q;

endmodule
